// File: rtl/sseg_capture.sv
// sseg_capture -- receive-side monitor for a multiplexed four-digit
// seven-segment display bus.
//
// The time-multiplexed digit enables and segment lines are synchronized.
// Each scan slot is debounced: {an,sseg} must hold for STABLE_CYC
// synchronized cycles. The slot's segment pattern is then decoded back to
// a hex value for the selected digit. Patterns that are not in the table
// are flagged. frame_done pulses once all four digits have been seen.
//
// Optional feature (compile-time macro):
//   SSEG_CAPTURE_BLANK_EN -- when defined, the all-segments-off pattern
//   (1111111) is accepted as a blank digit: hex=0, not valid, no error.
//   When undefined, that pattern is reported as undecodable.
//
// Parameters:
//   STABLE_CYC   cycles {an,sseg} must stay unchanged before capture (1..65535)
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   an[3:0]      digit enables, active low, bit i selects digit i
//   sseg[7:0]    bit7 decimal point (raw), bits 6:0 segments a..g active low
//   hex0..hex3   decoded digit values
//   dp_out[3:0]  captured decimal point per digit
//   digit_valid  bit i: last capture of digit i decoded successfully
//   seg_err      bit i: last capture of digit i was undecodable
//   frame_done   one-cycle pulse once all four digits have been captured
module sseg_capture #(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] dp_out,
  output logic [3:0] digit_valid,
  output logic [3:0] seg_err,
  output logic       frame_done
);

  localparam int              CW       = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYC);
  localparam logic [CW-1:0]   CNT_FIRE = CW'(STABLE_CYC - 1);
  localparam logic [11:0]     IDLE     = 12'hFFF;

  // Pattern to {matched, value}; a miss returns matched = 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    r = 5'b0_0000;
    case (s)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0000100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // True when exactly one digit enable is asserted (low).
  function automatic logic one_digit(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  logic [11:0]   sync_p0;
  logic [11:0]   sync_p1;
  logic [11:0]   hist_p2;
  logic [CW-1:0] cnt_p2;
  logic          stable_p2;
  logic          vld_p2;
  logic [3:0]    sel_p2;
  logic [4:0]    dec_p2;
  logic          blank_p2;
  logic [3:0]    mask_q;
  logic [3:0]    mask_nxt;
  logic [3:0]    hex_q [4];

  // Stage p0/p1: two-flop synchronizer on all twelve input bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= IDLE;
      sync_p1 <= IDLE;
    end else begin
      sync_p0 <= {an, sseg};
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: history register and saturating stability counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_p2 <= IDLE;
      cnt_p2  <= '0;
    end else begin
      hist_p2 <= sync_p1;
      if (stable_p2) begin
        if (cnt_p2 != CNT_MAX) cnt_p2 <= cnt_p2 + CW'(1);
      end else begin
        cnt_p2 <= '0;
      end
    end
  end

  // The capture strobe fires only on the STABLE_CYC-1 -> STABLE_CYC step,
  // so a long stable window yields exactly one capture.
  always_comb begin
    stable_p2 = (sync_p1 == hist_p2);
    sel_p2    = ~sync_p1[11:8];
    dec_p2    = decode_seg(sync_p1[6:0]);
    blank_p2  = (sync_p1[6:0] == 7'b1111111);
    vld_p2    = stable_p2 && (cnt_p2 == CNT_FIRE) && one_digit(sync_p1[11:8]);
    mask_nxt  = mask_q | (vld_p2 ? sel_p2 : 4'b0000);
  end

  // Stage p3: per-digit result registers and frame tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) hex_q[i] <= 4'h0;
      dp_out      <= 4'b0000;
      digit_valid <= 4'b0000;
      seg_err     <= 4'b0000;
      mask_q      <= 4'b0000;
      frame_done  <= 1'b0;
    end else begin
      if (vld_p2) begin
        for (int i = 0; i < 4; i++) begin
          if (sel_p2[i]) begin
            dp_out[i] <= sync_p1[7];
            if (dec_p2[4]) begin
              hex_q[i]       <= dec_p2[3:0];
              digit_valid[i] <= 1'b1;
              seg_err[i]     <= 1'b0;
            end else begin
`ifdef SSEG_CAPTURE_BLANK_EN
              if (blank_p2) begin
                hex_q[i]       <= 4'h0;
                digit_valid[i] <= 1'b0;
                seg_err[i]     <= 1'b0;
              end else begin
                digit_valid[i] <= 1'b0;
                seg_err[i]     <= 1'b1;
              end
`else
              digit_valid[i] <= 1'b0;
              seg_err[i]     <= 1'b1;
`endif
            end
          end
        end
      end
      // Completing the mask pulses frame_done and restarts tracking in the
      // same edge, so a capture on that edge is never lost.
      if (mask_nxt == 4'b1111) begin
        frame_done <= 1'b1;
        mask_q     <= 4'b0000;
      end else begin
        frame_done <= 1'b0;
        mask_q     <= mask_nxt;
      end
    end
  end

`ifndef SSEG_CAPTURE_BLANK_EN
  logic unused_blank;
  assign unused_blank = blank_p2;
`endif

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];

endmodule

// File: doc/sseg_capture.md
Name: sseg_capture

Overview:
- Receive-side counterpart of the team's multiplexed four-digit seven-segment driver.
- Samples the time-multiplexed digit-enable (`an`) and segment (`sseg`) buses and debounces each scan slot.
- Decodes the segment pattern back to a 4-bit hex value per digit and flags undecodable patterns.
- Used for board-level self-check of the parking-lot count display and as a display monitor in system benches.

Parameters:
- STABLE_CYC, 4: consecutive synchronized cycles `{an,sseg}` must hold unchanged before capture. Legal range 1..65535. Counter width is `$clog2(STABLE_CYC+1)`.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- an  input  4  digit enables, active low; bit i selects digit i
- sseg  input  8  bit7 = decimal point (raw, not inverted); bits 6:0 = segments a..g, active low
- hex0, hex1, hex2, hex3  output  4 each  decoded digit values
- dp_out  output  4  captured decimal point per digit
- digit_valid  output  4  bit i = last capture of digit i decoded successfully
- seg_err  output  4  bit i = last capture of digit i was an undecodable pattern
- frame_done  output  1  one-cycle pulse when all four digits have been captured since the previous pulse

Behaviour:
- Reset (asynchronous, reset_n low):
  - hex0..hex3, dp_out, digit_valid, seg_err, frame_done = 0.
  - Internal sync/history registers = idle value `an=4'b1111`, `sseg=8'hFF`.
  - Stability counter = 0; capture mask = 0.
  - Reset is honoured mid-operation with no partial update.
- Synchronizer: 2-flop synchronizer on all 12 input bits. A history register holds the previous synchronized value.
- Stability counter:
  - Increments when synchronized value == history, saturating at STABLE_CYC.
  - Clears to 0 on any mismatch.
  - A capture fires exactly once per stable window, on the edge where the counter goes STABLE_CYC-1 -> STABLE_CYC.
- Latency: an input first sampled at edge 0 and then held updates outputs at edge STABLE_CYC+2 (6 with default). Any change shorter than STABLE_CYC synchronized cycles produces no capture.
- Capture qualification:
  - Requires `an` to contain exactly one 0.
  - `an=1111` or multiple zeros: no capture, no output change, mask unchanged.
- Decode table for `sseg[6:0]`, active low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, a=0001000, b=1100000, c=0110001, d=1000010, e=0110000, f=0111000
- On a qualified capture of digit i:
  - `dp_out[i] <= sseg[7]`.
  - Pattern matches the table: `hex_i` <= value, `digit_valid[i]` <= 1, `seg_err[i]` <= 0.
  - No match: `hex_i` holds, `digit_valid[i]` <= 0, `seg_err[i]` <= 1.
  - Other digits are untouched.
- Frame tracking:
  - Capture mask bit i is set on any qualified capture of digit i, valid or error.
  - When the mask becomes 4'b1111, frame_done is high for exactly the next cycle and the mask clears in the same edge.
  - Repeat captures of the same digit before the frame completes are harmless.
- Outputs are all registered; no combinational path from inputs to outputs.

Optional Feature:
- SSEG_CAPTURE_BLANK_EN defined:
  - Pattern 1111111 (all segments off) is a legal blank.
  - Capture sets `hex_i`=0, `digit_valid[i]`=0, `seg_err[i]`=0, `dp_out[i]`=`sseg[7]`, and sets mask bit i.
- Not defined: 1111111 is treated as undecodable (`seg_err[i]`=1).

Test Plan:
- Reset: hold reset_n=0 with random inputs -> all outputs 0, frame_done never pulses. Release with `an=1111` held -> outputs remain 0.
- Single digit: STABLE_CYC=4, drive `an=1110`, `sseg=8'b0_0000110`, hold 10 cycles -> after edge 6, hex0=3, digit_valid=0001, dp_out=0000, seg_err=0000.
- Full frame: digits 3..0 = 1, 2, a, f with dp on digit 2, each held 8 cycles -> hex3=1, hex2=2, hex1=a, hex0=f, dp_out=0100, digit_valid=1111, exactly one frame_done pulse one cycle after the 4th capture.
- Glitch rejection: with digit 1 = 5 captured, drive `an=1101` with the '8' pattern for 3 cycles, then return -> hex1 stays 5, no capture.
- Error path: digit 2 with `sseg[6:0]=1111110` held 8 cycles -> seg_err[2]=1, digit_valid[2]=0, hex2 unchanged. Then '5' held 8 cycles -> hex2=5, seg_err[2]=0, digit_valid[2]=1.
- Illegal enables and mid-run reset: `an=1100` held 20 cycles -> no output change. Assert reset_n during a stable window -> all outputs 0 immediately; no capture fires until 6 cycles after release with a stable input.
